// File: rtl/row_sequencer.sv
// Row sequencer: steps a multiplier through NUM_ROWS rows, collects per-row
// overflow, guards each row with a watchdog and arbitrates memory writes.
module row_sequencer #(
    parameter int NUM_ROWS = 10,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_calc,
    input  logic                abort,
    input  logic                done_row,
    input  logic                overflow,
    input  logic                bus_wr_req,
    output logic [3:0]          row_select,
    output logic                begin_mult,
    output logic                w_result_ena,
    output logic [3:0]          in_sel,
    output logic                clear_data,
    output logic                busy,
    output logic                done_calc,
    output logic                error,
    output logic [NUM_ROWS-1:0] overflow_mask,
    output logic                mem_wr_en,
    output logic                bus_wr_stall
);

    localparam int                 TIMER_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);
    localparam logic [3:0]         ROW_LAST  = 4'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          row_r;
    logic [3:0]          row_s;
    logic [TIMER_W-1:0]  timer_r;
    logic [TIMER_W-1:0]  timer_s;
    logic [TIMER_W-1:0]  timer_inc_s;
    logic                error_r;
    logic                error_s;
    logic [NUM_ROWS-1:0] ovf_mask_r;
    logic [NUM_ROWS-1:0] ovf_mask_s;
    logic [NUM_ROWS-1:0] row_hit_s;

    // Saturating watchdog increment and one-hot decode of the active row
    always_comb begin
        if (timer_r == TIMER_MAX) begin
            timer_inc_s = TIMER_MAX;
        end else begin
            timer_inc_s = timer_r + TIMER_W'(1);
        end
        row_hit_s = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            row_hit_s[i] = (row_r == 4'(i));
        end
    end

    // Next-state, row, watchdog, error and overflow-mask logic
    always_comb begin
        state_s    = state_r;
        row_s      = row_r;
        timer_s    = timer_r;
        error_s    = error_r;
        ovf_mask_s = ovf_mask_r;
        // abort beats done_row and the watchdog, and leaves error untouched
        if ((state_r != IDLE) && abort) begin
            state_s = IDLE;
            row_s   = 4'd0;
            timer_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_calc && !abort) begin
                        state_s    = CLEAR;
                        row_s      = 4'd0;
                        error_s    = 1'b0;
                        ovf_mask_s = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CLEAR: begin
                    state_s = ISSUE;
                end
                ISSUE: begin
                    state_s = WAIT;
                    timer_s = '0;
                end
                WAIT: begin
                    if (done_row) begin
                        state_s    = STORE;
                        ovf_mask_s = (ovf_mask_r & ~row_hit_s) |
                                     (row_hit_s & {NUM_ROWS{overflow}});
                    end else begin
                        timer_s = timer_inc_s;
                        if (timer_inc_s == TIMER_MAX) begin
                            state_s = ERR;
                            error_s = 1'b1;
                        end else begin
                            state_s = WAIT;
                        end
                    end
                end
                STORE: begin
                    if (row_r == ROW_LAST) begin
                        state_s = DONE;
                    end else begin
                        state_s = ISSUE;
                        row_s   = row_r + 4'd1;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                    row_s   = 4'd0;
                end
                ERR: begin
                    state_s = IDLE;
                    row_s   = 4'd0;
                    error_s = 1'b1;
                end
                default: begin
                    state_s = IDLE;
                    row_s   = 4'd0;
                    timer_s = '0;
                end
            endcase
        end
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            row_r      <= 4'd0;
            timer_r    <= '0;
            error_r    <= 1'b0;
            ovf_mask_r <= '0;
        end else begin
            state_r    <= state_s;
            row_r      <= row_s;
            timer_r    <= timer_s;
            error_r    <= error_s;
            ovf_mask_r <= ovf_mask_s;
        end
    end

    // Moore strobes decoded from the registered state
    always_comb begin
        begin_mult   = 1'b0;
        w_result_ena = 1'b0;
        clear_data   = 1'b0;
        done_calc    = 1'b0;
        case (state_r)
            CLEAR:   clear_data   = 1'b1;
            ISSUE:   begin_mult   = 1'b1;
            STORE:   w_result_ena = 1'b1;
            DONE:    done_calc    = 1'b1;
            default: begin_mult   = 1'b0;
        endcase
    end

    assign busy          = (state_r != IDLE);
    assign row_select    = row_r;
    assign in_sel        = row_r;
    assign error         = error_r;
    assign overflow_mask = ovf_mask_r;
    // Bus writes go straight through only while the sequencer is idle
    assign mem_wr_en     = bus_wr_req & ~busy;
    assign bus_wr_stall  = bus_wr_req & busy;

endmodule
